// File: rtl/spi_pixel_receiver.sv
// -----------------------------------------------------------------------------
// spi_pixel_receiver
//
// Receive side of the 4-line SPI pixel link coming from the camera FPGA.
// The link clock, data, chip-select and end-of-frame lines are oversampled in
// the local clock domain. Nibbles are reassembled into DATA_WIDTH-bit pixels,
// MS nibble first. Each pixel is tagged with its column/row in the
// downsampled frame (H_PIXELS x V_PIXELS).
//
// Ports:
//   clk_in          - local clock, at least 4x the link dclk frequency
//   rst_n_in        - asynchronous active-low reset
//   chip_clk_in     - link data clock (asynchronous to clk_in)
//   chip_data_in    - link data lines, LINES wide
//   chip_sel_in     - link chip select, active-low
//   tlast_in        - high during the final pixel of a frame
//   pixel_valid_out - one-cycle strobe, a pixel is presented
//   pixel_data_out  - reassembled pixel, held until the next strobe
//   hcount_out      - column of the presented pixel
//   vcount_out      - row of the presented pixel
//   frame_done_out  - one-cycle strobe with pixel_valid_out on the tlast pixel
//   frame_error_out - sticky: tlast / frame position disagreement seen
// -----------------------------------------------------------------------------
module spi_pixel_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINES       = 4,
    parameter int H_PIXELS    = 160,
    parameter int V_PIXELS    = 90,
    parameter int SYNC_STAGES = 2,
    localparam int HW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1,
    localparam int VW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  chip_clk_in,
    input  logic [LINES-1:0]      chip_data_in,
    input  logic                  chip_sel_in,
    input  logic                  tlast_in,
    output logic                  pixel_valid_out,
    output logic [DATA_WIDTH-1:0] pixel_data_out,
    output logic [HW-1:0]         hcount_out,
    output logic [VW-1:0]         vcount_out,
    output logic                  frame_done_out,
    output logic                  frame_error_out
);

    localparam int NIBBLES = DATA_WIDTH / LINES;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    // All link inputs travel through one bundled synchronizer chain:
    // {tlast, sel, data, clk}
    localparam int SW      = LINES + 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchronizers
    // ---------------------------------------------------------------------
    logic [SW-1:0] w_raw;
    logic [SW-1:0] r_sync [SYNC_STAGES];
    logic [SW-1:0] w_sync;

    assign w_raw = {tlast_in, chip_sel_in, chip_data_in, chip_clk_in};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    logic             w_clk_s;
    logic [LINES-1:0] w_data_s;
    logic             w_sel_s;
    logic             w_tlast_s;

    assign w_clk_s   = w_sync[0];
    assign w_data_s  = w_sync[LINES:1];
    assign w_sel_s   = w_sync[LINES+1];
    assign w_tlast_s = w_sync[LINES+2];

    // ---------------------------------------------------------------------
    // Edge detection and nibble sampling
    // ---------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_next;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_next;
    logic                  r_clk_prev;
    logic                  w_rise;
    logic                  w_sample;
    logic                  w_last_nib;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tlast;
    logic [HW-1:0]         r_hcount;
    logic [VW-1:0]         r_vcount;
    logic                  w_at_end;

    assign w_rise     = w_clk_s & ~r_clk_prev;
    // An edge arriving while chip_sel is (already) high is dropped; EMIT is
    // never coincident with an edge under the link timing, so it is excluded
    // to keep the shift register stable while the pixel is captured.
    assign w_sample   = w_rise & ~w_sel_s & (r_state != S_EMIT);
    assign w_last_nib = (r_cnt == CW'(NIBBLES - 1));
    assign w_at_end   = (r_hcount == HW'(H_PIXELS - 1)) &&
                        (r_vcount == VW'(V_PIXELS - 1));

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE, S_SHIFT: begin
                if (w_sel_s) begin
                    // Deselect drops any partial pixel
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = S_SHIFT;
                    if (w_sample) begin
                        if (w_last_nib) begin
                            w_state_next = S_EMIT;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + 1'b1;
                        end
                    end
                end
            end
            S_EMIT: begin
                w_cnt_next   = '0;
                w_state_next = w_sel_s ? S_IDLE : S_SHIFT;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State, datapath and outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_clk_prev      <= 1'b0;
            r_shift         <= '0;
            r_tlast         <= 1'b0;
            r_hcount        <= '0;
            r_vcount        <= '0;
            pixel_valid_out <= 1'b0;
            pixel_data_out  <= '0;
            hcount_out      <= '0;
            vcount_out      <= '0;
            frame_done_out  <= 1'b0;
            frame_error_out <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_clk_prev <= w_clk_s;

            // MS nibble arrives first, so new nibbles enter at the LSB end
            if (w_sample) begin
                r_shift <= (r_shift << LINES) | DATA_WIDTH'(w_data_s);
            end
            // Only the tlast level on the final nibble of a pixel counts
            if (w_sample && w_last_nib) begin
                r_tlast <= w_tlast_s;
            end

            pixel_valid_out <= 1'b0;
            frame_done_out  <= 1'b0;

            if (r_state == S_EMIT) begin
                pixel_valid_out <= 1'b1;
                pixel_data_out  <= r_shift;
                hcount_out      <= r_hcount;
                vcount_out      <= r_vcount;
                frame_done_out  <= r_tlast;

                // tlast and the frame-end position must agree
                if (r_tlast != w_at_end) begin
                    frame_error_out <= 1'b1;
                end

                if (r_tlast || w_at_end) begin
                    r_hcount <= '0;
                    r_vcount <= '0;
                end else if (r_hcount == HW'(H_PIXELS - 1)) begin
                    r_hcount <= '0;
                    r_vcount <= r_vcount + 1'b1;
                end else begin
                    r_hcount <= r_hcount + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/spi_pixel_receiver.md
# spi_pixel_receiver

Receive side of the 4-line SPI pixel link driven by the peripheral FPGA's camera pipeline. Oversamples the link's clock, data, chip-select and end-of-frame lines in the local clock domain, and reassembles nibbles into 8-bit luminance pixels. Tags each pixel with its position in the downsampled frame (every 4th column and row of 640x360, i.e. 160x90). Sits on the main FPGA between the link input pins and the frame buffer / depth pipeline.

## Interface
Parameters:
- DATA_WIDTH, 8: bits per pixel.
- LINES, 4: parallel data lines; DATA_WIDTH/LINES nibbles per pixel (must divide evenly).
- H_PIXELS, 160: pixels per received row.
- V_PIXELS, 90: rows per received frame.
- SYNC_STAGES, 2: flip-flop synchronizer depth on every link input.

Ports:
- clk_in, input, 1: local clock; must be ≥4x the link dclk frequency.
- rst_n_in, input, 1: reset; one clock; reset is asynchronous and active-low.
- chip_clk_in, input, 1: link data clock (dclk), asynchronous to clk_in.
- chip_data_in, input, LINES: link data (cipo).
- chip_sel_in, input, 1: link chip select, active-low.
- tlast_in, input, 1: high during the final pixel of a frame.
- pixel_valid_out, output, 1: one-cycle strobe; a pixel is presented.
- pixel_data_out, output, DATA_WIDTH: reassembled pixel.
- hcount_out, output, $clog2(H_PIXELS): column of the presented pixel.
- vcount_out, output, $clog2(V_PIXELS): row of the presented pixel.
- frame_done_out, output, 1: one-cycle strobe coincident with pixel_valid_out for the tlast pixel.
- frame_error_out, output, 1: sticky flag; tlast/position mismatch seen.

## Operation
- Every link input passes through SYNC_STAGES flops. A rising edge is synced chip_clk low→high between consecutive cycles (edge register after the synchronizer).
- On a rising edge with synced chip_sel low, shift the synced chip_data into the pixel shift register. MS nibble is first, so data shifts in from the LSB end.
- FSM states:
  - IDLE: synced chip_sel high; nibble count held at 0. Go to SHIFT when chip_sel goes low.
  - SHIFT: count sampled nibbles.
    - On the edge that completes DATA_WIDTH/LINES nibbles, go to EMIT.
    - If chip_sel goes high first, return to IDLE and discard the partial pixel.
  - EMIT: one cycle. Register the pixel, present pixel_valid_out with the current hcount/vcount, reset the nibble count, then return to SHIFT (or IDLE if chip_sel is high).
- tlast handling: tlast_in is sampled on the edge of the last nibble of a pixel. A tlast value seen on earlier nibbles is ignored.
- Position counters advance after each emitted pixel:
  - hcount wraps H_PIXELS-1→0 and increments vcount.
  - vcount wraps V_PIXELS-1→0.
- On an emitted pixel with tlast, frame_done_out pulses and both counters load 0, whatever their value.
- frame_error_out sets on either of:
  - tlast pixel emitted at a position other than (H_PIXELS-1, V_PIXELS-1);
  - pixel emitted at (H_PIXELS-1, V_PIXELS-1) without tlast. Counters still wrap to (0,0).
- frame_error_out clears only on reset.
- Async reset while rst_n_in is low:
  - state IDLE; all counters, synchronizers and the shift register 0;
  - pixel_valid_out, frame_done_out, frame_error_out 0; pixel_data_out, hcount_out, vcount_out 0.
  - Reset mid-pixel discards the partial pixel. After release, the first completed pixel is at (0,0).

## Timing
- Latency: pixel_valid_out asserts SYNC_STAGES+2 clk_in cycles after the raw chip_clk rise that carries the final nibble (4 cycles at default).
- pixel_data_out, hcount_out and vcount_out are registered and stable from the valid cycle until the next valid. No ready/backpressure; the consumer must accept every strobe.
- Link constraints:
  - dclk high and low phases each ≥2 clk_in cycles.
  - chip_data/tlast stable ≥SYNC_STAGES cycles around the dclk rise; the sender changes data on the falling edge.
- Edge and chip_sel rising in the same cycle: the edge is ignored.
- Back-to-back pixels: the EMIT cycle never overlaps the next nibble edge given the minimum dclk phase.

## Test plan
- Single pixel: cs low, nibbles 0xA then 0x5, no tlast → one pixel_valid_out, pixel_data_out=0xA5, hcount_out=0, vcount_out=0, frame_error_out=0.
- Full frame: 14400 pixels, data = index[7:0], tlast on the last → 14400 valids; the last is at (159,89) with frame_done_out=1 in the same cycle; the next pixel is at (0,0); frame_error_out=0.
- Aborted pixel: after 3 good pixels, send one nibble 0xF, raise cs, lower cs, send 0x3C → no valid for the partial pixel; next valid is 0x3C at hcount=3.
- Early tlast: tlast on pixel 100 → valid at (100,0) with frame_done_out=1 and frame_error_out=1; the next pixel is at (0,0); the error stays set.
- Missing tlast: 14400 pixels without tlast → frame_error_out rises in the valid cycle of (159,89); the next pixel is at (0,0).
- Reset mid-pixel: assert rst_n_in low between nibbles of pixel 50 → all outputs 0 immediately, not at the next clk_in edge; after release, the next full pixel 0x77 is at (0,0).
